// File: rtl/ycbcr_src_sel_ctrl.sv
// Frame-synchronous source/pattern selector for the RGB->YCbCr converter.
// Picks camera, solid colour, colour bars or blink; mode changes land on start-of-frame.
module ycbcr_src_sel_ctrl #(
  parameter int unsigned BAR_W        = 80,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned FCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        cfg_mode,
  input  logic [23:0]       cfg_rgb,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              s_axis_video_tvalid,
  input  logic              s_axis_video_tready,
  input  logic              s_axis_video_tlast,
  input  logic              s_axis_video_tuser,
  output logic              Sel,
  output logic [23:0]       Sel_RGB,
  output logic [1:0]        active_mode,
  output logic              pending,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned PosW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PosW-1:0] PosLast = PosW'(BAR_W - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  localparam logic [1:0] ModeCam   = 2'd0;
  localparam logic [1:0] ModeSolid = 2'd1;
  localparam logic [1:0] ModeBars  = 2'd2;
  localparam logic [1:0] ModeBlink = 2'd3;

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e            state_q, state_d;
  logic [1:0]        pend_mode_q, act_mode_q;
  logic [23:0]       pend_rgb_q, act_rgb_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [PosW-1:0]   bar_pos_q, bar_pos_cur, bar_pos_d;
  logic [2:0]        bar_idx_q, bar_idx_cur, bar_idx_d;
  logic [BlkW-1:0]   blk_cnt_q, blk_cnt_adv;
  logic              blk_ph_q, blk_ph_adv, blk_ph_cur;

  logic        beat, sof, sof_pix, apply_pix, apply;
  logic [1:0]  eff_mode;
  logic [23:0] eff_rgb, bar_rgb;

  assign beat      = s_axis_video_tvalid & s_axis_video_tready;
  assign sof       = beat & s_axis_video_tuser;
  // SOF pixel on the bus, possibly still stalled: outputs must already show its mode.
  assign sof_pix   = s_axis_video_tvalid & s_axis_video_tuser;
  assign apply_pix = (state_q == StPend) & sof_pix;
  assign apply     = apply_pix & s_axis_video_tready;

  // Config FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cfg_valid) state_d = StPend;
      StPend: if (sof)       state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    pending   = 1'b0;
    unique case (state_q)
      StIdle: cfg_ready = 1'b1;
      StPend: pending   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_mode_q <= ModeCam;
      pend_rgb_q  <= '0;
      act_mode_q  <= ModeCam;
      act_rgb_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (state_q == StIdle && cfg_valid) begin
        pend_mode_q <= cfg_mode;
        pend_rgb_q  <= cfg_rgb;
      end
      if (apply) begin
        act_mode_q <= pend_mode_q;
        act_rgb_q  <= pend_rgb_q;
      end
      if (sof) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  // Bar position of the pixel currently presented, and of the one after it.
  always_comb begin
    bar_pos_cur = sof_pix ? '0 : bar_pos_q;
    bar_idx_cur = sof_pix ? '0 : bar_idx_q;
    bar_pos_d   = bar_pos_cur + PosW'(1);
    bar_idx_d   = bar_idx_cur;
    if (s_axis_video_tlast) begin
      bar_pos_d = '0;
      bar_idx_d = '0;
    end else if (bar_pos_cur == PosLast) begin
      bar_pos_d = '0;
      bar_idx_d = bar_idx_cur + 3'd1;
    end
  end

  // Blink phase of the frame that a SOF would start; a mode switch restarts at frame 0.
  always_comb begin
    blk_cnt_adv = blk_cnt_q + BlkW'(1);
    blk_ph_adv  = blk_ph_q;
    if (apply_pix) begin
      blk_cnt_adv = '0;
      blk_ph_adv  = 1'b0;
    end else if (blk_cnt_q == BlkLast) begin
      blk_cnt_adv = '0;
      blk_ph_adv  = ~blk_ph_q;
    end
    blk_ph_cur = sof_pix ? blk_ph_adv : blk_ph_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_pos_q <= '0;
      bar_idx_q <= '0;
      blk_cnt_q <= '0;
      blk_ph_q  <= 1'b0;
    end else begin
      if (beat) begin
        bar_pos_q <= bar_pos_d;
        bar_idx_q <= bar_idx_d;
      end
      if (sof) begin
        blk_cnt_q <= blk_cnt_adv;
        blk_ph_q  <= blk_ph_adv;
      end
    end
  end

  assign eff_mode = apply_pix ? pend_mode_q : act_mode_q;
  assign eff_rgb  = apply_pix ? pend_rgb_q  : act_rgb_q;

  always_comb begin
    unique case (bar_idx_cur)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFF00FF;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h0000FF;
      3'd4: bar_rgb = 24'hFFFF00;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h00FF00;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    Sel     = 1'b0;
    Sel_RGB = '0;
    unique case (eff_mode)
      ModeCam: ;
      ModeSolid: begin
        Sel     = 1'b1;
        Sel_RGB = eff_rgb;
      end
      ModeBars: begin
        Sel     = 1'b1;
        Sel_RGB = bar_rgb;
      end
      ModeBlink: begin
        if (blk_ph_cur) begin
          Sel     = 1'b1;
          Sel_RGB = eff_rgb;
        end
      end
    endcase
  end

  assign active_mode = act_mode_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ycbcr_src_sel_ctrl.sv
// Bench for ycbcr_src_sel_ctrl: randomized AXI handshakes checked against an
// integer pixel/frame model of the source-selection rules.
module tb_ycbcr_src_sel_ctrl;

  localparam int BW = 4;
  localparam int BF = 2;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    cm;
  logic [23:0]   crgb;
  logic          cv;
  logic          cfg_ready;
  logic          tv, tr, tl, tu;
  logic          Sel;
  logic [23:0]   Sel_RGB;
  logic [1:0]    active_mode;
  logic          pending;
  logic [FW-1:0] frame_cnt;

  always #5 clk = ~clk;

  ycbcr_src_sel_ctrl #(
    .BAR_W        (BW),
    .BLINK_FRAMES (BF),
    .FCNT_W       (FW)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .cfg_mode            (cm),
    .cfg_rgb             (crgb),
    .cfg_valid           (cv),
    .cfg_ready           (cfg_ready),
    .s_axis_video_tvalid (tv),
    .s_axis_video_tready (tr),
    .s_axis_video_tlast  (tl),
    .s_axis_video_tuser  (tu),
    .Sel                 (Sel),
    .Sel_RGB             (Sel_RGB),
    .active_mode         (active_mode),
    .pending             (pending),
    .frame_cnt           (frame_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                            24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

  // Reference model: pending request, applied mode, pixel index in line,
  // frame index since the last switch, SOF count.
  bit          m_pend;
  logic [1:0]  m_pmode, m_amode;
  logic [23:0] m_prgb, m_argb;
  int          m_p, m_k, m_fcnt;

  // Injection points (pixel index within a frame) for config requests.
  int          inj_a = -1, inj_b = -1;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] rgb_a, rgb_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_pend  = 0;
    m_pmode = 2'd0;
    m_prgb  = '0;
    m_amode = 2'd0;
    m_argb  = '0;
    m_p     = 0;
    m_k     = 0;
    m_fcnt  = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit          sp, e_sel, beat, sof, old_pend;
    int          p, k;
    logic [1:0]  md;
    logic [23:0] rgb, e_rgb;
    #3;
    sp    = tv & tu;
    p     = sp ? 0 : m_p;
    md    = (m_pend && sp) ? m_pmode : m_amode;
    rgb   = (m_pend && sp) ? m_prgb : m_argb;
    k     = sp ? (m_pend ? 0 : m_k + 1) : m_k;
    e_sel = 0;
    e_rgb = '0;
    case (md)
      2'd1: begin e_sel = 1; e_rgb = rgb; end
      2'd2: begin e_sel = 1; e_rgb = bars[(p / BW) % 8]; end
      2'd3: if (((k / BF) % 2) == 1) begin e_sel = 1; e_rgb = rgb; end
      default: ;
    endcase
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("pending", pending, m_pend);
    chk("active_mode", active_mode, m_amode);
    chk("frame_cnt", frame_cnt, m_fcnt);
    if (tv) begin
      chk("sel", Sel, e_sel);
      if (e_sel || md == 2'd0) chk("sel_rgb", Sel_RGB, e_rgb);
    end
    @(posedge clk);
    beat     = tv & tr;
    sof      = beat & tu;
    old_pend = m_pend;
    if (beat) m_p = tl ? 0 : p + 1;
    if (sof) begin
      m_fcnt = (m_fcnt + 1) % (1 << FW);
      if (old_pend) begin
        m_amode = m_pmode;
        m_argb  = m_prgb;
        m_k     = 0;
        m_pend  = 0;
      end else begin
        m_k++;
      end
    end
    if (!old_pend && cv) begin
      m_pmode = cm;
      m_prgb  = crgb;
      m_pend  = 1;
    end
    #1;
  endtask

  task automatic frame(input int nlines, input int len);
    int  px;
    int  tries;
    bit  done;
    px = 0;
    for (int l = 0; l < nlines; l++) begin
      for (int i = 0; i < len; i++) begin
        tu = (l == 0 && i == 0);
        tl = (i == len - 1);
        if (px == inj_a || px == inj_b) begin
          cv   = 1'b1;
          cm   = (px == inj_a) ? mode_a : mode_b;
          crgb = (px == inj_a) ? rgb_a : rgb_b;
          tv   = 1'b1;
          tr   = 1'b1;
          cycle();
          cv   = 1'b0;
        end else begin
          tries = 0;
          do begin
            tv   = ($urandom_range(3) != 0) || tries > 20;
            tr   = ($urandom_range(2) != 0) || tries > 20;
            done = tv & tr;
            cycle();
            tries++;
          end while (!done);
        end
        px++;
      end
    end
    tv    = 1'b0;
    tu    = 1'b0;
    tl    = 1'b0;
    inj_a = -1;
    inj_b = -1;
  endtask

  initial begin
    rstn = 1'b0;
    cm   = 2'd0;
    crgb = '0;
    cv   = 1'b0;
    tv   = 1'b0;
    tr   = 1'b0;
    tl   = 1'b0;
    tu   = 1'b0;
    reset_model();
    #12;
    chk("rst_sel", Sel, 1'b0);
    chk("rst_sel_rgb", Sel_RGB, 24'h0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_pending", pending, 1'b0);
    chk("rst_active_mode", active_mode, 2'd0);
    chk("rst_frame_cnt", frame_cnt, 4'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Solid colour requested mid-frame, applied at the next SOF.
    inj_a = 5; mode_a = 2'd1; rgb_a = 24'h123456;
    frame(2, 40);
    frame(2, 40);
    // Request on the SOF beat (deferred a frame), second request while pending ignored.
    inj_a = 0;  mode_a = 2'd2; rgb_a = 24'hABCDEF;
    inj_b = 10; mode_b = 2'd1; rgb_b = 24'hFF0000;
    frame(2, 40);
    frame(3, 40);
    // One-pixel lines: tuser and tlast together; then switch to blink.
    inj_a = 1; mode_a = 2'd3; rgb_a = 24'h00FF00;
    frame(3, 1);
    for (int f = 0; f < 6; f++) frame(2, 6);

    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(1) == 1) begin
        inj_a  = $urandom_range(3);
        mode_a = 2'($urandom_range(3));
        rgb_a  = 24'($urandom);
      end
      frame($urandom_range(3, 1), $urandom_range(12, 1));
    end

    // Asynchronous reset in the middle of a frame.
    inj_a = 2; mode_a = 2'd1; rgb_a = 24'h654321;
    frame(1, 20);
    tv = 1'b1; tr = 1'b1; tu = 1'b1; tl = 1'b0;
    cycle();
    tu = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_sel", Sel, 1'b0);
    chk("midrst_sel_rgb", Sel_RGB, 24'h0);
    chk("midrst_cfg_ready", cfg_ready, 1'b1);
    chk("midrst_pending", pending, 1'b0);
    chk("midrst_active_mode", active_mode, 2'd0);
    chk("midrst_frame_cnt", frame_cnt, 4'd0);
    tv = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    reset_model();
    frame(2, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
